// File: rtl/instr_register_mc_if.sv
// Handshake, execute-status and register-file read bundle for instr_register_mc.
interface instr_register_mc_if #(
  parameter int OP_WIDTH   = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RES_WIDTH  = 2 * OP_WIDTH
);
  logic                  load_valid;
  logic                  load_ready;
  logic [3:0]            opcode;
  logic [OP_WIDTH-1:0]   operand_a;
  logic [OP_WIDTH-1:0]   operand_b;
  logic [ADDR_WIDTH-1:0] write_pointer;
  logic [ADDR_WIDTH-1:0] read_pointer;
  logic [3:0]            rd_opcode;
  logic [OP_WIDTH-1:0]   rd_operand_a;
  logic [OP_WIDTH-1:0]   rd_operand_b;
  logic [RES_WIDTH-1:0]  rd_result;
  logic                  rd_valid;
  logic                  rd_error;
  logic                  busy;
  logic                  done;
  logic [15:0]           instr_count;

  modport master (
    output load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
    input  load_ready, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
           rd_valid, rd_error, busy, done, instr_count
  );

  modport slave (
    input  load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
    output load_ready, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
           rd_valid, rd_error, busy, done, instr_count
  );
endinterface

// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register: accepts one instruction per handshake,
// executes it (bit-serial DIV/MOD/POW) and writes word plus result to a register file.
module instr_register_mc #(
  parameter int OP_WIDTH   = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RES_WIDTH  = 2 * OP_WIDTH
) (
  input logic                clk,
  input logic                reset,
  instr_register_mc_if.slave bus
);

  localparam int CNT_W = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7,
    OP_POW   = 4'd8
  } opcode_e;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [OP_WIDTH-1:0]  operand_a;
    logic [OP_WIDTH-1:0]  operand_b;
    logic [RES_WIDTH-1:0] result;
    logic                 valid;
    logic                 error;
  } entry_t;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [OP_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [RES_WIDTH-1:0]  acc_q, acc_d;
  logic                  done_q, done_d;
  logic [15:0]           count_q, count_d;
  entry_t                rf_q [DEPTH];
  entry_t                rf_d [DEPTH];

  logic                  accept_c, iter_c, last_step_c;
  logic [OP_WIDTH:0]     rem_shift_c;
  logic                  div_ge_c;
  logic [OP_WIDTH-1:0]   rem_next_c, quo_next_c;
  logic [RES_WIDTH-1:0]  sq_c, pow_next_c, result_c;
  logic                  error_c;
  entry_t                rd_e;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one accept in IDLE, leave EXEC on the final step
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.load_valid) state_d = S_EXEC;
      S_EXEC: if (last_step_c)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.load_ready = (state_q == S_IDLE);
    bus.busy       = (state_q == S_EXEC);
  end

  // Execute unit: one restoring-divider bit and one square-and-multiply bit per cycle, MSB first
  always_comb begin
    accept_c    = (state_q == S_IDLE) && bus.load_valid;
    iter_c      = (op_q == OP_POW) || (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q != '0));
    last_step_c = (state_q == S_EXEC) && (!iter_c || (cnt_q == '0));

    rem_shift_c = {rem_q, a_q[cnt_q]};
    div_ge_c    = (rem_shift_c >= {1'b0, b_q});
    rem_next_c  = div_ge_c ? OP_WIDTH'(rem_shift_c - {1'b0, b_q}) : rem_shift_c[OP_WIDTH-1:0];
    quo_next_c  = {quo_q[OP_WIDTH-2:0], div_ge_c};

    sq_c        = acc_q * acc_q;
    pow_next_c  = b_q[cnt_q] ? sq_c * RES_WIDTH'(a_q) : sq_c;

    result_c = '0;
    error_c  = 1'b0;
    case (op_q)
      OP_ZERO:  result_c = '0;
      OP_PASSA: result_c = RES_WIDTH'(a_q);
      OP_PASSB: result_c = RES_WIDTH'(b_q);
      OP_ADD:   result_c = RES_WIDTH'(a_q) + RES_WIDTH'(b_q);
      OP_SUB:   result_c = RES_WIDTH'(a_q) - RES_WIDTH'(b_q);
      OP_MULT:  result_c = RES_WIDTH'(a_q) * RES_WIDTH'(b_q);
      OP_DIV:   if (b_q == '0) error_c = 1'b1; else result_c = RES_WIDTH'(quo_next_c);
      OP_MOD:   if (b_q == '0) error_c = 1'b1; else result_c = RES_WIDTH'(rem_next_c);
      OP_POW:   result_c = pow_next_c;
      default:  error_c = 1'b1;
    endcase
  end

  // Instruction capture and iteration state
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    acc_d  = acc_q;
    if (accept_c) begin
      op_d   = bus.opcode;
      a_d    = bus.operand_a;
      b_d    = bus.operand_b;
      wptr_d = bus.write_pointer;
      cnt_d  = CNT_W'(OP_WIDTH - 1);
      rem_d  = '0;
      quo_d  = '0;
      acc_d  = RES_WIDTH'(1);
    end else if ((state_q == S_EXEC) && iter_c) begin
      cnt_d  = cnt_q - 1'b1;
      rem_d  = rem_next_c;
      quo_d  = quo_next_c;
      acc_d  = pow_next_c;
    end
  end

  // Capture/iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      acc_q  <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      acc_q  <= acc_d;
    end
  end

  // Write-back: out-of-range pointers still complete (done, count) but store nothing
  always_comb begin
    rf_d    = rf_q;
    done_d  = 1'b0;
    count_d = count_q;
    if (last_step_c) begin
      done_d  = 1'b1;
      count_d = count_q + 16'd1;
      if (int'(wptr_q) < DEPTH) begin
        rf_d[wptr_q].opcode    = op_q;
        rf_d[wptr_q].operand_a = a_q;
        rf_d[wptr_q].operand_b = b_q;
        rf_d[wptr_q].result    = result_c;
        rf_d[wptr_q].valid     = 1'b1;
        rf_d[wptr_q].error     = error_c;
      end
    end
  end

  // Register file and completion status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      done_q  <= done_d;
      count_q <= count_d;
      rf_q    <= rf_d;
    end
  end

  // Combinational read port and status outputs
  always_comb begin
    rd_e = '0;
    if (int'(bus.read_pointer) < DEPTH) rd_e = rf_q[bus.read_pointer];
    bus.rd_opcode    = rd_e.opcode;
    bus.rd_operand_a = rd_e.operand_a;
    bus.rd_operand_b = rd_e.operand_b;
    bus.rd_result    = rd_e.result;
    bus.rd_valid     = rd_e.valid;
    bus.rd_error     = rd_e.error;
    bus.done         = done_q;
    bus.instr_count  = count_q;
  end

endmodule

// File: doc/instr_register_mc.md
Name: instr_register_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle instruction register. It accepts one instruction per valid/ready handshake and executes it in an internal execute unit. Simple ops take 1 cycle; DIV/MOD/POW run bit-serially for OP_WIDTH cycles. The complete instruction word and its result are written into a DEPTH-entry register file, which is read combinationally by the checker or scoreboard side of the lab testbench.

Parameters:
OP_WIDTH, 32, operand width in bits; operands are unsigned
DEPTH, 32, number of register-file entries
ADDR_WIDTH, $clog2(DEPTH), pointer width
RES_WIDTH, 2*OP_WIDTH, stored result width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
load_valid  in  1  instruction offered
load_ready  out  1  block can accept an instruction
opcode  in  4  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD, 8 POW; 9-15 illegal
operand_a  in  OP_WIDTH  first operand
operand_b  in  OP_WIDTH  second operand
write_pointer  in  ADDR_WIDTH  destination entry
read_pointer  in  ADDR_WIDTH  entry to read
rd_opcode  out  4  opcode stored at read_pointer
rd_operand_a  out  OP_WIDTH  operand_a stored at read_pointer
rd_operand_b  out  OP_WIDTH  operand_b stored at read_pointer
rd_result  out  RES_WIDTH  result stored at read_pointer
rd_valid  out  1  entry has been written since reset
rd_error  out  1  entry holds an illegal-opcode or divide-by-zero result
busy  out  1  execution in progress
done  out  1  one-cycle pulse after each write-back
instr_count  out  16  number of write-backs since reset; wraps at 0xFFFF

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE and load_ready=1; busy=0, done=0, instr_count=0.
  - Every entry is cleared to opcode 0, operands 0, result 0, valid 0, error 0.
  - An in-flight instruction is discarded and nothing is written.
- FSM states are IDLE and EXEC.
- IDLE:
  - load_ready=1, busy=0.
  - On load_valid&&load_ready at an edge: capture opcode, operands and write_pointer, then go to EXEC.
  - Inputs are don't-care outside the accept edge.
- EXEC:
  - load_ready=0, busy=1.
  - Lasts 1 cycle for ZERO, PASSA, PASSB, ADD, SUB, MULT, illegal opcodes, and DIV/MOD with b=0.
  - Lasts OP_WIDTH cycles for DIV, MOD and POW. An internal counter counts OP_WIDTH-1 down to 0.
  - On the final EXEC edge: write the entry, set valid=1, return to IDLE, increment instr_count.
  - done=1 for exactly the following cycle, during which load_ready=1 again. Back-to-back accepts are allowed.
- Latency from accept edge to write edge: 1 cycle for simple ops, OP_WIDTH cycles for iterative ops.
- Arithmetic (all results zero-extended to RES_WIDTH):
  - ZERO gives 0.
  - PASSA gives a; PASSB gives b.
  - ADD gives a+b, keeping the carry.
  - SUB gives (a-b) mod 2^RES_WIDTH, i.e. it wraps.
  - MULT gives the full 2*OP_WIDTH product.
- DIV and MOD:
  - Computed by a restoring divider that handles one quotient bit per cycle, MSB first.
  - DIV gives the quotient; MOD gives the remainder.
  - b=0 gives result 0 and error=1.
- POW:
  - Computed MSB-first by square-and-multiply, one bit of b per cycle; each step is truncated mod 2^RES_WIDTH.
  - b=0 gives 1; 0^0 gives 1.
- Illegal opcode: result 0, error=1, opcode stored as given.
- Read port is combinational from read_pointer.
  - A write to the same entry becomes visible in the cycle after the write edge.
- Pointer bounds:
  - A write_pointer >= DEPTH drops the write; done still pulses and instr_count still increments.
  - A read_pointer >= DEPTH returns all zeros with rd_valid=0.
- Simultaneous reset and accept: reset wins.

Test Plan:
1. After reset, read all entries: every field is 0 and rd_valid=0. load_ready=1, instr_count=0.
2. ADD a=5 b=7 to ptr 3:
   - busy is 1 for 1 cycle, then done pulses.
   - Entry 3 reads rd_result=12, valid=1, error=0.
   - Then MULT a=0xFFFFFFFF b=2 to ptr 4: rd_result=0x1_FFFFFFFE.
3. DIV a=100 b=7 to ptr 5, then MOD a=100 b=7 to ptr 6:
   - Each instruction holds busy for exactly 32 cycles and load_ready=0 throughout.
   - Results are 14 and 2.
   - DIV a=9 b=0: result 0, error=1, busy for 1 cycle.
4. POW a=3 b=4: result 81 after 32 cycles. POW a=2 b=70: result 0 (truncated). POW a=9 b=0: result 1.
5. Start DIV to ptr 8 and assert reset at EXEC cycle 10:
   - Entry 8 has valid=0, busy=0, no done pulse.
   - After release, ADD 1+1 to ptr 8 gives 2.
6. Issue 4 back-to-back SUB a=3 b=5 with load_valid held high:
   - Accepts occur every 2 cycles.
   - Each result is 0xFFFFFFFF_FFFFFFFE; instr_count=4.
   - Illegal opcode 12 stores error=1 and result 0.
